// File: rtl/adc_eq_pkg.sv
// adc_eq_pkg: shared types for the ADC capture / equalizer path.
//   SAMPLE_W         : sample width in bits
//   sample_t         : signed two's-complement sample
//   cap_state_t      : capture FSM states
//   offset_to_signed : offset-binary ADC code -> signed sample
package adc_eq_pkg;

    localparam int SAMPLE_W = 12;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        ARM        = 2'd0,
        WAIT_FRAME = 2'd1,
        PUSH       = 2'd2
    } cap_state_t;

    // Offset-binary to two's complement is an MSB flip: 0x800 -> 0.
    function automatic sample_t offset_to_signed(input logic [SAMPLE_W-1:0] code);
        return sample_t'({~code[SAMPLE_W-1], code[SAMPLE_W-2:0]});
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage, no fall-through.
//   clk_adc, rst_adc : clock, async active-high reset
//   push, wdata      : write request / data (ignored when full unless popping)
//   pop              : read request (ignored when empty)
//   rdata            : head entry
//   full, empty      : status
//   level            : occupancy 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk_adc,
    input  logic             rst_adc,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the head slot in the same cycle, so a full FIFO still
    // accepts a write when it is being read.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk_adc or posedge rst_adc) begin
        if (rst_adc) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo: captures complete serial-ADC frames, converts the
// offset-binary code to signed, optionally removes DC, and buffers samples
// for the equalizer filter bank.
//   clk_adc, rst_adc : clock, async active-high reset
//   cs_i, data_i     : converter chip-select (high = idle) and captured code
//   ready_i          : downstream accepts sample_o
//   sample_o/valid_o : FIFO head and its valid
//   level_o          : FIFO occupancy
//   overflow_o       : sticky, a sample was dropped on a full FIFO
// Build option: define ADC_DC_BLOCK_EN to enable the DC-blocking tracker
// (time constant 2^DC_SHIFT frames); otherwise samples pass unmodified.
module adc_sample_fifo
    import adc_eq_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int DC_SHIFT = 8
) (
    input  logic                       clk_adc,
    input  logic                       rst_adc,
    input  logic                       cs_i,
    input  logic [SAMPLE_W-1:0]        data_i,
    input  logic                       ready_i,
    output logic [SAMPLE_W-1:0]        sample_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o
);

    cap_state_t state, state_nx;
    logic    cs_d;
    logic    cs_seen;
    logic    push;
    logic    pop;
    logic    full;
    logic    empty;
    sample_t x_q;
    sample_t y;

    assign pop     = valid_o && ready_i;
    assign valid_o = !empty;

    // cs_seen: after reset a frame may already be in progress; only a low
    // phase that follows an observed idle-high counts as a frame start.
    always_ff @(posedge clk_adc or posedge rst_adc) begin
        if (rst_adc) begin
            state      <= ARM;
            cs_d       <= 1'b1;
            cs_seen    <= 1'b0;
            x_q        <= '0;
            overflow_o <= 1'b0;
        end else begin
            state <= state_nx;
            cs_d  <= cs_i;
            if (cs_i) cs_seen <= 1'b1;
            if (state == WAIT_FRAME && cs_i && !cs_d) x_q <= offset_to_signed(data_i);
            if (push && full && !pop) overflow_o <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        push     = 1'b0;
        case (state)
            ARM:        if (!cs_i && cs_seen) state_nx = WAIT_FRAME;
            WAIT_FRAME: if (cs_i && !cs_d)    state_nx = PUSH;
            PUSH: begin
                push     = 1'b1;
                state_nx = ARM;
            end
            default:    state_nx = ARM;
        endcase
    end

`ifdef ADC_DC_BLOCK_EN
    // acc holds the running mean scaled by 2^8; acc[19:8] is the mean in LSBs.
    logic signed [19:0] acc;
    logic signed [12:0] diff;
    logic signed [20:0] err;

    assign diff = 13'(x_q) - 13'($signed(acc[19:8]));
    assign err  = $signed({x_q[SAMPLE_W-1], x_q, 8'b0}) - 21'(acc);

    always_comb begin
        y = diff[11:0];
        if (diff[12] != diff[11]) y = diff[12] ? sample_t'(12'h800) : sample_t'(12'h7FF);
    end

    always_ff @(posedge clk_adc or posedge rst_adc) begin
        if (rst_adc)   acc <= '0;
        else if (push) acc <= acc + 20'(err >>> DC_SHIFT);
    end
`else
    logic unused_dc_shift;
    assign unused_dc_shift = (DC_SHIFT != 0);
    assign y               = x_q;
`endif

    sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_adc (clk_adc),
        .rst_adc (rst_adc),
        .push    (push),
        .wdata   (y),
        .pop     (pop),
        .rdata   (sample_o),
        .full    (full),
        .empty   (empty),
        .level   (level_o)
    );

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Directed bench for adc_sample_fifo (DEPTH=8). Expected samples are queued
// when a frame is driven and compared when the DUT presents them.
module tb_adc_sample_fifo;

    logic        clk_adc = 1'b0;
    logic        rst_adc = 1'b1;
    logic        cs_i    = 1'b1;
    logic [11:0] data_i  = '0;
    logic        ready_i = 1'b0;
    logic [11:0] sample_o;
    logic        valid_o;
    logic [3:0]  level_o;
    logic        overflow_o;

    int total = 0;
    int bad   = 0;
    logic [11:0] exp_q [$];

    adc_sample_fifo #(.DEPTH(8), .DC_SHIFT(8)) dut (
        .clk_adc    (clk_adc),
        .rst_adc    (rst_adc),
        .cs_i       (cs_i),
        .data_i     (data_i),
        .ready_i    (ready_i),
        .sample_o   (sample_o),
        .valid_o    (valid_o),
        .level_o    (level_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_adc = ~clk_adc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_adc);
        #1;
    endtask

    // Low phase then rising edge; returns in the cycle cs_i is high (cycle N).
    task automatic frame(input logic [11:0] d);
        step(1);
        cs_i = 1'b0;
        step(2);
        data_i = d;
        cs_i   = 1'b1;
    endtask

    // Pop head with a one-cycle ready_i pulse, checking it against the queue.
    task automatic pop_chk(input string tag);
        logic [11:0] e;
        chk({tag, "_valid"}, valid_o, 1);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, sample_o, e);
        end
        ready_i = 1'b1;
        step(1);
        ready_i = 1'b0;
    endtask

    initial begin
        logic [11:0] d;
        step(3);
        chk("rst_valid", valid_o, 0);
        chk("rst_level", level_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_sample", sample_o, 0);
        rst_adc = 1'b0;
        step(2);

`ifdef ADC_DC_BLOCK_EN
        ready_i = 1'b1;
        for (int i = 0; i < 4096; i++) frame(12'hA00);
        step(2);
        chk("dc_valid", valid_o, 1);
        chk("dc_conv", (($signed(sample_o) <= 2) && ($signed(sample_o) >= -2)), 1);
        ready_i = 1'b0;
`else
        // Single mid-scale frame, latency and immediate pop.
        ready_i = 1'b1;
        frame(12'h800);
        exp_q.push_back(12'h000);
        step(1);
        chk("lat_n1_valid", valid_o, 0);
        step(1);
        chk("lat_n2_level", level_o, 1);
        pop_chk("mid_sample");
        chk("mid_level_after", level_o, 0);

        // Two samples held while ready_i low.
        ready_i = 1'b0;
        frame(12'hFFF); exp_q.push_back(12'h7FF); step(2);
        frame(12'h000); exp_q.push_back(12'h800); step(2);
        chk("two_level", level_o, 2);
        chk("two_head", sample_o, 12'h7FF);
        step(3);
        chk("two_hold", sample_o, 12'h7FF);
        pop_chk("two_pop0");
        pop_chk("two_pop1");
        chk("two_level_end", level_o, 0);

        // Fill to DEPTH.
        for (int i = 0; i < 8; i++) begin
            d = 12'(i * 12'h123 + 12'h011);
            frame(d);
            exp_q.push_back(d ^ 12'h800);
            step(2);
        end
        chk("full_level", level_o, 8);
        chk("full_ovf", overflow_o, 0);

        // Push coincident with pop on a full FIFO.
        frame(12'h5A5);
        step(1);                      // PUSH cycle
        chk("coin_head", sample_o, exp_q[0]);
        void'(exp_q.pop_front());
        exp_q.push_back(12'h5A5 ^ 12'h800);
        ready_i = 1'b1;
        step(1);
        ready_i = 1'b0;
        chk("coin_level", level_o, 8);
        chk("coin_ovf", overflow_o, 0);

        // Ninth sample on full FIFO is dropped.
        frame(12'h3C3);
        step(2);
        chk("drop_level", level_o, 8);
        chk("drop_ovf", overflow_o, 1);
        for (int i = 0; i < 8; i++) pop_chk($sformatf("drain%0d", i));
        chk("drain_level", level_o, 0);
        chk("drain_valid", valid_o, 0);
        ready_i = 1'b1;
        step(2);
        chk("empty_level", level_o, 0);
        chk("ovf_sticky", overflow_o, 1);
        ready_i = 1'b0;

        // Reset mid-frame discards the partial frame.
        cs_i = 1'b0;
        step(1);
        rst_adc = 1'b1;
        step(2);
        rst_adc = 1'b0;
        step(3);
        data_i = 12'h123;
        cs_i   = 1'b1;
        step(4);
        chk("midrst_level", level_o, 0);
        chk("midrst_ovf", overflow_o, 0);
        frame(12'h456);
        exp_q.push_back(12'hC56);
        step(8);                      // cs_i stays high: one sample only
        chk("post_rst_level", level_o, 1);
        pop_chk("post_rst_sample");
        chk("post_rst_end", level_o, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_sample_fifo.md
ADC_SAMPLE_FIFO -- requirements
Module: adc_sample_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO depth in samples; power of two, 2..64.
REQ-002 Parameter DC_SHIFT, default 8, DC-tracker time constant as a right-shift amount, 4..12.
REQ-003 clk_adc  in  1  clock; all logic on rising edge.
REQ-004 rst_adc  in  1  reset, asynchronous, active-high.
REQ-005 cs_i  in  1  converter chip-select from the serial ADC capture stage; high = frame complete/idle.
REQ-006 data_i  in  12  captured ADC code, offset-binary, stable while cs_i high.
REQ-007 ready_i  in  1  downstream equalizer filter bank accepts a sample.
REQ-008 sample_o  out  12  signed two's-complement sample, FIFO head.
REQ-009 valid_o  out  1  sample_o valid.
REQ-010 level_o  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-011 overflow_o  out  1  sticky: a sample was dropped.

Function
REQ-012 Capture FSM SHALL have states ARM, WAIT_FRAME, PUSH.
REQ-013 ARM: wait for cs_i==0 -> WAIT_FRAME; guarantees only complete frames are captured.
REQ-014 WAIT_FRAME: on cs_i rising edge (cs_i==1, registered cs_d==0) latch data_i -> PUSH.
REQ-015 PUSH: one cycle; write converted sample into FIFO -> ARM.
REQ-016 Conversion: signed = {~data_i[11], data_i[10:0]} (0x800 -> 0, 0xFFF -> +2047, 0x000 -> -2048).
REQ-017 Latency: cs_i rising at cycle N -> write at end of N+1 -> valid_o high at N+2 (FIFO empty case); no combinational fall-through.
REQ-018 Handshake: pop occurs on cycle with valid_o && ready_i; sample_o SHALL hold stable while valid_o && !ready_i.
REQ-019 Full and PUSH without pop: sample dropped, FIFO unchanged, overflow_o set 1 next cycle, stays 1 until reset.
REQ-020 Full and PUSH with pop same cycle: both SHALL occur, no overflow, level unchanged.
REQ-021 Empty: valid_o=0, ready_i ignored; level_o never underflows.
REQ-022 Read/write pointers $clog2(DEPTH) bits, wrap modulo DEPTH; level_o = writes minus reads, range 0..DEPTH.
REQ-023 cs_i high for multiple cycles SHALL yield exactly one sample per rising edge.

Reset
REQ-024 On rst_adc: FSM=ARM, cs_d=1 (no spurious edge at release since upstream resets cs high), pointers=0, level_o=0, valid_o=0, sample_o=0, overflow_o=0, DC accumulator=0.
REQ-025 Reset mid-frame SHALL discard the partial frame; first capture requires a cs_i low-then-high sequence.

Configuration
REQ-026 Macro ADC_DC_BLOCK_EN.
REQ-027 Defined: 20-bit signed accumulator acc tracks mean; at PUSH, y = x - acc[19:8] saturated to [-2048,+2047]; acc <= acc + ((x<<8) - acc) >>> DC_SHIFT; y is written.
REQ-028 Undefined: x (REQ-016) written directly; accumulator logic absent; DC_SHIFT unused.
REQ-029 Latency (REQ-017) SHALL be identical in both builds.

Structure
REQ-030 Shared package adc_eq_pkg: SAMPLE_W=12, sample_t signed typedef, capture-state enum, offset-to-signed conversion function.
REQ-031 One sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/level) instantiated once; FSM, conversion and DC block in top.

Verification
REQ-032 Single frame, data_i=0x800, ready_i=1, DC block off -> valid_o at N+2, sample_o=0x000, pop next cycle, level 1->0.
REQ-033 data_i=0xFFF then 0x000, ready_i=0 -> level_o=2, sample_o=0x7FF held, then 0x800 after pop.
REQ-034 DEPTH=8, ready_i=0, 9 frames -> level_o=8, overflow_o=1 after 9th, first 8 samples intact in order.
REQ-035 Full FIFO, frame PUSH coincident with pop -> level_o stays 8, overflow_o stays 0.
REQ-036 rst_adc pulsed mid-frame (cs_i low), then cs_i rises -> no capture; next full low-high frame captured normally.
REQ-037 ADC_DC_BLOCK_EN defined, constant data_i=0xA00 for 4096 frames -> sample_o magnitude converges to <=2 LSB of 0.
